// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder that sits behind the core's load/store request port.
//   It accepts one request per cycle, performs the byte/half/word store or the
//   word load against an internal synchronous word array, and returns in-order
//   responses through a 2-entry FIFO. This lets the consumer stall without any
//   response being lost.
//
//   Optional feature macro: DMEM_MISALIGN_CHK_EN
//     defined   : a misaligned half or word access faults (resp_err, no write)
//     undefined : the low address bits are ignored; the access is aligned down
//
// Ports
//   clk         clock, rising edge
//   arst_n      asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10/11 word
//   req_addr    byte address
//   req_wdata   right-aligned store data
//   resp_valid  response present (FIFO head)
//   resp_ready  consumer takes the response
//   resp_rdata  aligned word for loads; 0 for stores and faults
//   resp_err    access faulted; no write was performed
module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int DMEM_SZ_IN_KB = 1,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = DMEM_SZ_IN_KB * 1024 / 4;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  accept;
  logic [IDX_W-1:0]      word_idx;
  logic                  range_err;
  logic                  misalign_err;
  logic                  req_err;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wdata_lanes;

  logic                  inflight_q;
  logic                  inflight_err_q;
  logic                  inflight_we_q;

  logic [DATA_WIDTH-1:0] fifo_rdata [0:1];
  logic                  fifo_err   [0:1];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_next;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_rdata;
  logic [2:0]            pending;

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[2 +: IDX_W];

  // Any set bit above the array span puts the address out of range.
  assign range_err = |req_addr[ADDR_WIDTH-1:IDX_W+2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign_err = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif

  assign req_err = range_err || misalign_err;

  // Lane selection. Half uses addr[1] only and word uses no low bits, so an
  // unchecked misaligned access is naturally forced down to its boundary.
  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  // The array has no reset, so its contents survive arst_n.
  always_ff @(posedge clk) begin
    if (accept && !req_err) begin
      if (req_we) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) begin
            mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
          end
        end
      end else begin
        rd_word <= mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
      inflight_we_q  <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        inflight_err_q <= req_err;
        inflight_we_q  <= req_we;
      end
    end
  end

  // rd_word is only meaningful for a good load; acks and faults carry zero.
  assign push       = inflight_q;
  assign push_rdata = (inflight_we_q || inflight_err_q) ? '0 : rd_word;
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_rdata[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      count_q <= count_next;
      if (push) begin
        fifo_rdata[wr_ptr_q] <= push_rdata;
        fifo_err[wr_ptr_q]   <= inflight_err_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // The in-flight slot counts as occupied. This keeps the FIFO from
  // overflowing, and a same-cycle pop frees a slot in time for
  // back-to-back throughput.
  assign pending   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = pending < 3'd2;

  assign resp_valid = (count_q != 2'd0);
  assign resp_rdata = resp_valid ? fifo_rdata[rd_ptr_q] : '0;
  assign resp_err   = resp_valid && fifo_err[rd_ptr_q];

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table-driven request vectors with a response
// scoreboard, plus directed sequences for latency, backpressure and reset.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam int NV = 25;

  logic        clk;
  logic        arst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .DATA_WIDTH(32),
    .DMEM_SZ_IN_KB(1),
    .ADDR_WIDTH(32)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];

  int   checks = 0;
  int   errors = 0;
  bit   rr_rand = 1'b0;

  bit          prev_hold = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
  endtask

  // Called on a negedge. Holds the request until it is accepted, pushes the
  // expected response, and returns on the following negedge.
  task automatic issue(input bit we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err, output int waits);
    bit done;
    bit timed_out;
    exp_t e;
    waits     = 0;
    done      = 1'b0;
    timed_out = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    while (!done) begin
      #1;
      if (req_ready) begin
        done = 1'b1;
      end else if (waits >= 100) begin
        done      = 1'b1;
        timed_out = 1'b1;
      end else begin
        waits++;
        tick();
      end
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_ready stayed %b, expected 1 within 100 cycles", req_ready);
      req_valid = 1'b0;
      tick();
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
      tick();
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      #2;
      n++;
    end
    chk(name, sb.size(), 0);
    tick();
  endtask

  // Response monitor: checks popped responses against the scoreboard and
  // checks that a stalled head stays stable.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!arst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", resp_valid, 1'b1);
        chk("hold_rdata", resp_rdata, prev_rdata);
        chk("hold_err", resp_err, prev_err);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got rdata %h err %b, expected no response", resp_rdata, resp_err);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
        end
      end
      prev_hold  = resp_valid && !resp_ready;
      prev_rdata = resp_rdata;
      prev_err   = resp_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int acc;
    exp_t e;

    vecs[0]  = '{1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 32'h0000_0010, 32'h1122_3344, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 32'h0000_0013, 32'h0000_00AA, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'hAA22_3344, 1'b0};
    vecs[5]  = '{1'b1, 2'b01, 32'h0000_0012, 32'h0000_5566, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h5566_3344, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 32'h0000_0012, 32'h0, 32'h5566_3344, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 32'h0000_0000, 32'h0102_0304, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 32'h0000_0400, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 2'b10, 32'h0000_0000, 32'h0, 32'h0102_0304, 1'b0};
    vecs[12] = '{1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 2'b10, 32'h0000_0020, 32'h0, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 2'b10, 32'h0000_0022, 32'hCAFE_F00D, 32'h0, MIS};
    vecs[15] = '{1'b0, 2'b10, 32'h0000_0020, 32'h0, (MIS ? 32'h0 : 32'hCAFE_F00D), 1'b0};
    vecs[16] = '{1'b1, 2'b10, 32'h0000_03FC, 32'h0, 32'h0, 1'b0};
    vecs[17] = '{1'b1, 2'b00, 32'h0000_03FF, 32'h0000_0077, 32'h0, 1'b0};
    vecs[18] = '{1'b0, 2'b10, 32'h0000_03FC, 32'h0, 32'h7700_0000, 1'b0};
    vecs[19] = '{1'b1, 2'b01, 32'h0000_0011, 32'h0000_BBCC, 32'h0, MIS};
    vecs[20] = '{1'b0, 2'b10, 32'h0000_0010, 32'h0, (MIS ? 32'h5566_3344 : 32'h5566_BBCC), 1'b0};
    vecs[21] = '{1'b1, 2'b11, 32'h0000_0030, 32'h1234_5678, 32'h0, 1'b0};
    vecs[22] = '{1'b1, 2'b00, 32'h0000_0031, 32'hFFFF_FF99, 32'h0, 1'b0};
    vecs[23] = '{1'b0, 2'b10, 32'h0000_0030, 32'h0, 32'h1234_9978, 1'b0};
    vecs[24] = '{1'b0, 2'b00, 32'h0000_0033, 32'h0, 32'h1234_9978, 1'b0};

    // Reset state
    arst_n     = 1'b0;
    resp_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    tick();
    arst_n = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    tick();

    // Store then load: the load response is valid one cycle after accept
    issue(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, w);
    idle();
    repeat (3) tick();
    issue(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    idle();
    #1;
    chk("lat_accept_cycle", resp_valid, 1'b0);
    tick();
    #1;
    chk("lat_next_cycle", resp_valid, 1'b1);
    tick();
    wait_drain("drain_lat");

    // Vector table back-to-back with continuous resp_ready: no stalls
    stalls = 0;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
            vecs[i].rdata, vecs[i].err, w);
      stalls += w;
    end
    idle();
    chk("throughput_stalls", stalls, 0);
    wait_drain("drain_tbl1");

    // Same table under random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
            vecs[i].rdata, vecs[i].err, w);
    end
    idle();
    rr_rand    = 1'b0;
    resp_ready = 1'b1;
    wait_drain("drain_tbl2");

    // Consumer stalled with requests offered continuously: exactly two accepts
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready) begin
        acc++;
        e.rdata = 32'h0102_0304;
        e.err   = 1'b0;
        sb.push_back(e);
      end
      tick();
    end
    #1;
    chk("bp_accepts", acc, 2);
    chk("bp_req_ready", req_ready, 1'b0);
    tick();
    resp_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'b10, 32'h0, 32'h0, 32'h0102_0304, 1'b0, w);
      stalls += w;
    end
    idle();
    chk("bp_release_stalls", stalls, 0);
    wait_drain("drain_bp");

    // Reset with two queued responses
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 32'h0, 32'h0, 32'h0102_0304, 1'b0, w);
    issue(1'b0, 2'b10, 32'h10, 32'h0, (MIS ? 32'h5566_3344 : 32'h5566_BBCC), 1'b0, w);
    idle();
    tick();
    tick();
    #1;
    chk("pre_rst_valid", resp_valid, 1'b1);
    tick();
    arst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 1'b0);
    sb.delete();
    tick();
    arst_n     = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_valid", resp_valid, 1'b0);
    tick();
    issue(1'b0, 2'b10, 32'h0, 32'h0, 32'h0102_0304, 1'b0, w);
    issue(1'b0, 2'b10, 32'h30, 32'h0, 32'h1234_9978, 1'b0, w);
    idle();
    wait_drain("drain_rst");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
